// File: rtl/teletext_scheduler_pkg.sv
// Shared types for the teletext renderer and its scheduler: timing/character
// structs, scheduler state encoding and default page geometry.
package teletext_types;

  localparam int unsigned DefColumns   = 40;
  localparam int unsigned DefRows      = 25;
  localparam int unsigned DefScanlines = 10;

  typedef struct packed {
    logic       valid;
    logic [6:0] character;
  } t_character;

  typedef struct packed {
    logic       restart_frame;
    logic       end_of_scanline;
    logic       first_scanline_of_row;
    logic       smoothe;
    logic [1:0] interpolate_vertical;
  } t_timings;

  typedef enum logic [2:0] {
    StIdle,
    StWaitLine,
    StFetch,
    StDrain,
    StEndLine
  } t_sched_state;

endpackage

// File: rtl/teletext_sched_counters.sv
// Column, scanline, row and row_base counters for the teletext scheduler.
// row_base accumulates COLUMNS per row so addresses need no multiplier.
module teletext_sched_counters
  import teletext_types::*;
#(
  parameter int unsigned COLUMNS   = DefColumns,
  parameter int unsigned ROWS      = DefRows,
  parameter int unsigned SCANLINES = DefScanlines
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        col_inc,
  input  logic        line_done,
  input  logic        smoothe,
  output logic [5:0]  col,
  output logic        col_last,
  output logic [4:0]  scanline,
  output logic [10:0] row_base,
  output logic        frame_last
);

  logic [5:0]  col_q;
  logic [4:0]  scan_q;
  logic [5:0]  row_q;
  logic [10:0] base_q;
  logic [5:0]  scan_limit;
  logic        scan_last;

  // With smoothing each ROM scanline is emitted twice, doubling the row height.
  always_comb begin
    scan_limit = smoothe ? 6'(2 * SCANLINES) : 6'(SCANLINES);
    scan_last  = ({1'b0, scan_q} == (scan_limit - 6'd1));
    col_last   = (col_q == 6'(COLUMNS - 1));
    frame_last = scan_last && (row_q == 6'(ROWS - 1));
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      col_q  <= '0;
      scan_q <= '0;
      row_q  <= '0;
      base_q <= '0;
    end else begin
      if (col_inc) begin
        col_q <= col_last ? 6'd0 : col_q + 6'd1;
      end
      if (line_done) begin
        if (scan_last) begin
          scan_q <= '0;
          row_q  <= row_q + 6'd1;
          base_q <= base_q + 11'(COLUMNS);
        end else begin
          scan_q <= scan_q + 5'd1;
        end
      end
    end
  end

  assign col      = col_q;
  assign scanline = scan_q;
  assign row_base = base_q;

endmodule

// File: rtl/teletext_scheduler.sv
// Fetches one character row per line_start from the frame-buffer SRAM and drives
// the teletext renderer. Optional smoothing: define TELETEXT_SCHEDULER_SMOOTHE_EN.
module teletext_scheduler
  import teletext_types::*;
#(
  parameter int unsigned COLUMNS   = DefColumns,
  parameter int unsigned ROWS      = DefRows,
  parameter int unsigned SCANLINES = DefScanlines
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        line_start,
  input  logic        smoothe_enable,
  output logic        fb_select,
  output logic [10:0] fb_address,
  input  logic [6:0]  fb_data,
  output logic        character__valid,
  output logic [6:0]  character__character,
  output logic        timings__restart_frame,
  output logic        timings__end_of_scanline,
  output logic        timings__first_scanline_of_row,
  output logic        timings__smoothe,
  output logic [1:0]  timings__interpolate_vertical,
  output logic        line_overrun
);

  t_sched_state state_q, state_d;
  logic         restart_q;
  logic         valid_q;
  logic         overrun_q;
  logic         busy;
  logic         line_done;
  logic         smoothe_active;
  logic [1:0]   interp;
  logic [5:0]   col;
  logic         col_last;
  logic [4:0]   scanline;
  logic [10:0]  row_base;
  logic         frame_last;
  t_timings     timings;
  t_character   character;

  assign busy      = (state_q == StFetch) || (state_q == StDrain) || (state_q == StEndLine);
  assign line_done = (state_q == StEndLine);

  teletext_sched_counters #(
    .COLUMNS  (COLUMNS),
    .ROWS     (ROWS),
    .SCANLINES(SCANLINES)
  ) u_counters (
    .clk       (clk),
    .reset     (reset),
    .clear     (frame_start),
    .col_inc   (state_q == StFetch),
    .line_done (line_done),
    .smoothe   (smoothe_active),
    .col       (col),
    .col_last  (col_last),
    .scanline  (scanline),
    .row_base  (row_base),
    .frame_last(frame_last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     state_d = StIdle;
      StWaitLine: if (line_start) state_d = StFetch;
      StFetch:    if (col_last) state_d = StDrain;
      StDrain:    state_d = StEndLine;
      StEndLine:  state_d = frame_last ? StIdle : StWaitLine;
      default:    state_d = StIdle;
    endcase
    // A new frame aborts whatever line is in flight.
    if (frame_start) state_d = StWaitLine;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      restart_q <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      restart_q <= frame_start;
      valid_q   <= fb_select && !frame_start;
      if (frame_start) begin
        overrun_q <= 1'b0;
      end else if (line_start && busy) begin
        overrun_q <= 1'b1;
      end
    end
  end

`ifdef TELETEXT_SCHEDULER_SMOOTHE_EN
  logic smoothe_q;
  logic phase_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      smoothe_q <= 1'b0;
      phase_q   <= 1'b0;
    end else if (frame_start) begin
      smoothe_q <= smoothe_enable;
      phase_q   <= 1'b0;
    end else if (line_done) begin
      phase_q <= ~phase_q;
    end
  end

  assign smoothe_active = smoothe_q;
  assign interp         = smoothe_q ? (phase_q ? 2'b10 : 2'b01) : 2'b00;
`else
  logic unused_smoothe_enable;
  assign unused_smoothe_enable = smoothe_enable;
  assign smoothe_active        = 1'b0;
  assign interp                = 2'b00;
`endif

  always_comb begin
    timings.restart_frame         = restart_q;
    timings.end_of_scanline       = (state_q == StEndLine);
    timings.first_scanline_of_row = busy && (scanline == 5'd0);
    timings.smoothe               = smoothe_active;
    timings.interpolate_vertical  = interp;
    character.valid               = valid_q;
    // SRAM output register is the pipeline stage; gate it so idle output is 0.
    character.character           = valid_q ? fb_data : 7'd0;
  end

  assign fb_select                      = (state_q == StFetch);
  assign fb_address                     = row_base + {5'd0, col};
  assign character__valid               = character.valid;
  assign character__character           = character.character;
  assign timings__restart_frame         = timings.restart_frame;
  assign timings__end_of_scanline       = timings.end_of_scanline;
  assign timings__first_scanline_of_row = timings.first_scanline_of_row;
  assign timings__smoothe               = timings.smoothe;
  assign timings__interpolate_vertical  = timings.interpolate_vertical;
  assign line_overrun                   = overrun_q;

endmodule

// File: tb/tb_teletext_scheduler.sv
// Self-checking bench for teletext_scheduler: timing-arithmetic reference model
// compared every cycle, plus directed literal checks.
module tb_teletext_scheduler;

  localparam int C = 40;
  localparam int R = 25;
  localparam int S = 10;
`ifdef TELETEXT_SCHEDULER_SMOOTHE_EN
  localparam bit SmBuilt = 1'b1;
`else
  localparam bit SmBuilt = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        frame_start;
  logic        line_start;
  logic        smoothe_enable;
  logic        fb_select;
  logic [10:0] fb_address;
  logic [6:0]  fb_data;
  logic        character__valid;
  logic [6:0]  character__character;
  logic        timings__restart_frame;
  logic        timings__end_of_scanline;
  logic        timings__first_scanline_of_row;
  logic        timings__smoothe;
  logic [1:0]  timings__interpolate_vertical;
  logic        line_overrun;

  teletext_scheduler #(
    .COLUMNS  (C),
    .ROWS     (R),
    .SCANLINES(S)
  ) dut (
    .clk                           (clk),
    .reset                         (reset),
    .frame_start                   (frame_start),
    .line_start                    (line_start),
    .smoothe_enable                (smoothe_enable),
    .fb_select                     (fb_select),
    .fb_address                    (fb_address),
    .fb_data                       (fb_data),
    .character__valid              (character__valid),
    .character__character          (character__character),
    .timings__restart_frame        (timings__restart_frame),
    .timings__end_of_scanline      (timings__end_of_scanline),
    .timings__first_scanline_of_row(timings__first_scanline_of_row),
    .timings__smoothe              (timings__smoothe),
    .timings__interpolate_vertical (timings__interpolate_vertical),
    .line_overrun                  (line_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] mem [0:2047];
  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 7'((i * 13 + 7) % 128);
    fb_data = 7'd0;
  end
  always @(posedge clk) if (fb_select) fb_data <= mem[fb_address];

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  bit ce = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
  endtask

  // Reference model: a line is a window of cycles after its accepted line_start.
  bit m_active, m_frame, m_smooth, m_ovr;
  int m_t, m_line, m_accepted, m_restart_at;

  function automatic int lim();
    return m_smooth ? 2 * S : S;
  endfunction

  always @(posedge clk) begin : model
    bit busy_n;
    busy_n = m_active && (cyc >= m_t + 1) && (cyc <= m_t + C + 2);
    if (reset) begin
      m_active = 0; m_frame = 0; m_smooth = 0; m_ovr = 0;
      m_accepted = 0; m_restart_at = -1;
    end else if (frame_start) begin
      m_active = 0; m_frame = 1; m_accepted = 0; m_ovr = 0;
      m_smooth = SmBuilt && smoothe_enable;
      m_restart_at = cyc + 1;
    end else if (line_start) begin
      if (busy_n) m_ovr = 1;
      else if (m_frame && m_accepted < R * lim()) begin
        m_active = 1; m_t = cyc; m_line = m_accepted; m_accepted++;
      end
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin : compare
    bit busy, e_sel, e_val;
    int base, scan, off;
    logic [6:0] e_char;
    if (ce) begin
      busy  = m_active && (cyc >= m_t + 1) && (cyc <= m_t + C + 2);
      e_sel = m_active && (cyc >= m_t + 1) && (cyc <= m_t + C);
      e_val = m_active && (cyc >= m_t + 2) && (cyc <= m_t + C + 1);
      base  = (m_line / lim()) * C;
      scan  = busy ? (m_line % lim()) : (m_accepted % lim());
      off   = cyc - m_t - 2;
      e_char = e_val ? mem[base + off] : 7'd0;
      chk("fb_select", fb_select, e_sel);
      if (e_sel) chk("fb_address", fb_address, base + cyc - m_t - 1);
      chk("valid", character__valid, e_val);
      chk("character", character__character, e_char);
      chk("end_of_scanline", timings__end_of_scanline, m_active && (cyc == m_t + C + 2));
      chk("first_scanline", timings__first_scanline_of_row, busy && (m_line % lim() == 0));
      chk("restart_frame", timings__restart_frame, cyc == m_restart_at);
      chk("smoothe", timings__smoothe, m_smooth);
      chk("interp", timings__interpolate_vertical,
          m_smooth ? ((scan % 2 == 1) ? 2'b10 : 2'b01) : 2'b00);
      chk("line_overrun", line_overrun, m_ovr);
    end
  end

  int ln_nsel, ln_neos, ln_nval, ln_rst;
  logic [10:0] ln_a0, ln_alast;
  logic ln_fsr, ln_ovr;
  logic [1:0] ln_iv;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives line_start at k=0 and optional extra pulses, observing C+3 cycles.
  task automatic do_line(input int ov_k, input int fs_k, input int rs_k);
    ln_nsel = 0; ln_neos = 0; ln_nval = 0; ln_rst = 0;
    ln_a0 = '0; ln_alast = '0; ln_fsr = 0; ln_ovr = 0; ln_iv = 2'b00;
    for (int k = 0; k <= C + 2; k++) begin
      line_start  = (k == 0) || (k == ov_k);
      frame_start = (k == fs_k);
      reset       = (k == rs_k);
      @(negedge clk);
      if (fb_select) begin
        if (ln_nsel == 0) ln_a0 = fb_address;
        ln_alast = fb_address;
        ln_nsel++;
      end
      if (timings__end_of_scanline) ln_neos++;
      if (timings__first_scanline_of_row) ln_fsr = 1;
      if (character__valid) ln_nval++;
      if (timings__restart_frame) ln_rst++;
      if (k == 1) ln_iv = timings__interpolate_vertical;
      ln_ovr = line_overrun;
      tick();
    end
    line_start = 0; frame_start = 0; reset = 0;
  endtask

  task automatic pulse_frame(input logic sm);
    frame_start = 1; smoothe_enable = sm;
    tick();
    frame_start = 0; smoothe_enable = 0;
    @(negedge clk);
    chk("lit_restart", timings__restart_frame, 1);
    tick();
  endtask

  initial begin
    reset = 1; frame_start = 0; line_start = 0; smoothe_enable = 0;
    tick();
    ce = 1;
    tick();
    @(negedge clk);
    chk("lit_reset_select", fb_select, 0);
    chk("lit_reset_valid", character__valid, 0);
    chk("lit_reset_overrun", line_overrun, 0);
    chk("lit_reset_eos", timings__end_of_scanline, 0);
    tick();
    reset = 0;

    do_line(-1, -1, -1);
    chk("lit_idle_line_nsel", ln_nsel, 0);
    chk("lit_idle_line_ovr", ln_ovr, 0);

    pulse_frame(1'b0);
    for (int i = 0; i <= R * S; i++) begin
      do_line(-1, -1, -1);
      if (i == 0) begin
        chk("lit_l0_nsel", ln_nsel, C);
        chk("lit_l0_a0", ln_a0, 0);
        chk("lit_l0_alast", ln_alast, 39);
        chk("lit_l0_nval", ln_nval, C);
        chk("lit_l0_neos", ln_neos, 1);
        chk("lit_l0_fsr", ln_fsr, 1);
      end
      if (i == 9) chk("lit_l9_fsr", ln_fsr, 0);
      if (i == 10) begin
        chk("lit_l10_a0", ln_a0, 40);
        chk("lit_l10_fsr", ln_fsr, 1);
      end
      if (i == R * S - 1) begin
        chk("lit_last_a0", ln_a0, 960);
        chk("lit_last_alast", ln_alast, 999);
      end
      if (i == R * S) begin
        chk("lit_extra_nsel", ln_nsel, 0);
        chk("lit_extra_ovr", ln_ovr, 0);
      end
      if (i % 7 == 3) tick();
    end

    pulse_frame(1'b0);
    do_line(10, -1, -1);
    chk("lit_ovr_nsel", ln_nsel, C);
    chk("lit_ovr_neos", ln_neos, 1);
    chk("lit_ovr_flag", ln_ovr, 1);

    do_line(20, 20, -1);
    chk("lit_abort_nsel", ln_nsel, 20);
    chk("lit_abort_neos", ln_neos, 0);
    chk("lit_abort_rst", ln_rst, 1);
    chk("lit_abort_ovr", ln_ovr, 0);
    do_line(-1, -1, -1);
    chk("lit_after_abort_a0", ln_a0, 0);
    chk("lit_after_abort_nsel", ln_nsel, C);

    do_line(-1, -1, 15);
    chk("lit_rst_nsel", ln_nsel, 15);
    chk("lit_rst_neos", ln_neos, 0);
    do_line(-1, -1, -1);
    chk("lit_post_rst_nsel", ln_nsel, 0);
    pulse_frame(1'b0);
    do_line(-1, -1, -1);
    chk("lit_post_rst_a0", ln_a0, 0);
    chk("lit_post_rst_nsel2", ln_nsel, C);

    pulse_frame(1'b1);
    @(negedge clk);
    chk("lit_smoothe", timings__smoothe, SmBuilt);
    tick();
`ifdef TELETEXT_SCHEDULER_SMOOTHE_EN
    for (int i = 0; i <= 2 * R * S; i++) begin
      do_line(-1, -1, -1);
      if (i == 0) begin
        chk("lit_sm0_iv", ln_iv, 2'b01);
        chk("lit_sm0_fsr", ln_fsr, 1);
      end
      if (i == 1) begin
        chk("lit_sm1_iv", ln_iv, 2'b10);
        chk("lit_sm1_fsr", ln_fsr, 0);
        chk("lit_sm1_a0", ln_a0, 0);
      end
      if (i == 19) chk("lit_sm19_fsr", ln_fsr, 0);
      if (i == 20) begin
        chk("lit_sm20_fsr", ln_fsr, 1);
        chk("lit_sm20_a0", ln_a0, 40);
        chk("lit_sm20_iv", ln_iv, 2'b01);
      end
      if (i == 2 * R * S - 1) chk("lit_sm_last_a0", ln_a0, 960);
      if (i == 2 * R * S) chk("lit_sm_extra_nsel", ln_nsel, 0);
    end
`else
    do_line(-1, -1, -1);
    chk("lit_nosm_iv", ln_iv, 2'b00);
    do_line(-1, -1, -1);
    chk("lit_nosm_a0", ln_a0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/teletext_scheduler.md
# teletext_scheduler

Sequencer that drives the `teletext` character-rendering block from a character frame buffer. On each display line request it fetches one row of character codes from a synchronous-read frame-buffer SRAM, streams them to `teletext` as `character__*`, and generates the `timings__*` framing strobes. Row, scanline and column counters are kept here, so the renderer and the display timing generator stay stateless with respect to page layout.

## Interface
Parameters:
- COLUMNS, 40, characters per row (2..64)
- ROWS, 25, character rows per frame (1..32)
- SCANLINES, 10, ROM scanlines per character row (1..16)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frame_start  in  1  single-cycle pulse: start new frame
- line_start  in  1  single-cycle pulse: render next scanline
- smoothe_enable  in  1  request character smoothing (sampled at frame_start)
- fb_select  out  1  frame-buffer read strobe
- fb_address  out  11  frame-buffer address, row*COLUMNS+col
- fb_data  in  7  character code, valid the cycle after fb_select
- character__valid  out  1  character strobe to renderer
- character__character  out  7  character code
- timings__restart_frame  out  1  one-cycle pulse per accepted frame_start
- timings__end_of_scanline  out  1  one-cycle pulse after the last character
- timings__first_scanline_of_row  out  1  high for the whole first output scanline of a row
- timings__smoothe  out  1  smoothing active this frame
- timings__interpolate_vertical  out  2  vertical interpolation phase
- line_overrun  out  1  sticky: line_start arrived while busy; cleared by frame_start or reset

## Operation
- States: IDLE, WAIT_LINE, FETCH, DRAIN, END_LINE.
- IDLE: wait for frame_start. From any state, frame_start clears the row, scanline and column counters, row_base and line_overrun. It latches smoothe_enable, pulses restart_frame next cycle and goes to WAIT_LINE. Any in-flight line is aborted with no end_of_scanline.
- WAIT_LINE: line_start moves to FETCH.
- FETCH: issue COLUMNS consecutive reads, col 0..COLUMNS-1, at fb_address = row_base + col. row_base is an accumulator: it adds COLUMNS on each row advance. No multiplier.
- DRAIN: one cycle for the last read data to return.
- END_LINE: pulse end_of_scanline, then advance the scanline counter.
  - When the scanline reaches the per-row limit (SCANLINES, or 2*SCANLINES when smoothing), the scanline wraps to 0 and the row increments.
  - When the row reaches ROWS, go to IDLE; otherwise go to WAIT_LINE.
- first_scanline_of_row = (scanline counter == 0) while in FETCH, DRAIN or END_LINE; 0 elsewhere.
- Smoothing: each ROM scanline is output twice. interpolate_vertical = 2'b01 on even output scanlines and 2'b10 on odd ones. It is 2'b00 when not smoothing.
- Boundaries:
  - line_start in FETCH, DRAIN or END_LINE: ignored and sets line_overrun.
  - line_start in IDLE: ignored, flag unchanged.
  - frame_start and line_start in the same cycle: frame wins, line_start is dropped and not flagged.
- Reset values: every output 0, state IDLE, all counters 0.

## Timing
- line_start at cycle t (WAIT_LINE): fb_select high t+1..t+COLUMNS.
- character__valid high t+2..t+COLUMNS+1. character__character = fb_data registered straight through, 1-cycle SRAM latency.
- end_of_scanline high at t+COLUMNS+2. Earliest next accepted line_start is t+COLUMNS+3.
- restart_frame is one cycle after frame_start.
- smoothe and interpolate_vertical are registered and stable across a whole scanline.

## Configuration
- TELETEXT_SCHEDULER_SMOOTHE_EN defined:
  - smoothe_enable is honoured.
  - Rows span 2*SCANLINES output scanlines.
  - interpolate_vertical toggles as above.
- Not defined:
  - smoothe_enable is ignored.
  - timings__smoothe and timings__interpolate_vertical are tied 0.
  - Rows span SCANLINES output scanlines.
  - The phase counter logic is removed.

## Structure
- Shared package `teletext_types` holds:
  - the timings and character struct types, already shared with `teletext`;
  - the state enum t_sched_state;
  - the default geometry constants (40/25/10).
- One sub-module: `teletext_sched_counters`, which holds the column, scanline, row and row_base counters with wrap outputs. The FSM stays in the top.

## Test plan
- Reset, then frame_start, then one line_start at t:
  - restart_frame at frame_start+1.
  - fb_address 0..39 on t+1..t+40.
  - 40 valid characters t+2..t+41, matching preloaded SRAM.
  - end_of_scanline at t+42.
  - first_scanline_of_row=1 throughout.
- Full frame of 250 line_starts, smoothing off:
  - row 1 addresses start at 40 on the 11th line.
  - The final line reads 960..999.
  - The 251st line_start produces no fb_select.
- Macro defined, smoothe_enable=1:
  - 500 lines per frame.
  - interpolate_vertical alternates 01/10.
  - first_scanline_of_row is asserted on output lines 0, 20, 40….
- line_start at t+10 of an active line: ignored, line_overrun=1, the current line completes normally.
- frame_start at t+20 mid-line:
  - fb_select drops at the next cycle, no end_of_scanline, restart_frame pulses.
  - The next line reads address 0.
  - line_overrun is cleared.
- reset asserted mid-FETCH: all outputs 0 next cycle, FSM in IDLE, line_start ignored until frame_start.
